vball_rom_arbiter: RTL and testbench

//  Shares the single external ROM read port (SDRAM side) between the BG tile fetcher (bg_read/bg_addr)
//  and the PCM sample fetcher (pcm_rom_read/pcm_rom_addr). BG has priority; PCM gets an anti-starvation

---
 rtl/vball_pkg.sv | 29 ++
 rtl/rom_req_slot.sv | 61 ++++++
 rtl/vball_rom_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vball_rom_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vball_pkg.sv
// Shared types and defaults for the vball ROM port arbiter.
package vball_pkg;

    localparam int unsigned ROM_AW  = 25;
    localparam int unsigned BG_AW   = 19;
    localparam int unsigned PCM_AW  = 18;
    localparam int unsigned DATA_W  = 8;

    localparam logic [ROM_AW-1:0] DEF_BG_BASE  = 25'h100000;
    localparam logic [ROM_AW-1:0] DEF_PCM_BASE = 25'h180000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_BG  = 1'b0,
        OWN_PCM = 1'b1
    } owner_e;

    // Region base plus zero-extended offset, wrapping at the ROM address width.
    function automatic logic [ROM_AW-1:0] map_addr(input logic [ROM_AW-1:0] base,
                                                   input logic [ROM_AW-1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/rom_req_slot.sv
// Per-requester state: pending request, address latch, one-entry hit register, data/ready outputs.
module rom_req_slot
    import vball_pkg::*;
#(
    parameter int unsigned AW = 19
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              req_read,
    input  logic [AW-1:0]     req_addr,
    input  logic              pend_clr,
    input  logic              hit_ack,
    input  logic              fill_en,
    input  logic [AW-1:0]     fill_addr,
    input  logic              deliver_en,
    input  logic [DATA_W-1:0] deliver_data,
    input  logic              inval,
    output logic              pend,
    output logic [AW-1:0]     addr,
    output logic              hit_c,
    output logic [DATA_W-1:0] data,
    output logic              rdy
);

    logic [AW-1:0] haddr;
    logic          hv;

    assign hit_c = pend && hv && (addr == haddr);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend  <= 1'b0;
            addr  <= '0;
            haddr <= '0;
            hv    <= 1'b0;
            data  <= '0;
            rdy   <= 1'b0;
        end else begin
            // A new request wins over a clear in the same cycle.
            if (req_read) begin
                pend <= 1'b1;
                addr <= req_addr;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            if (inval) begin
                hv <= 1'b0;
            end else if (fill_en) begin
                hv    <= 1'b1;
                haddr <= fill_addr;
            end

            if (deliver_en) begin
                data <= deliver_data;
            end
            rdy <= hit_ack | deliver_en;
        end
    end

endmodule

// File: rtl/vball_rom_arbiter.sv
// Shares the external ROM read port between the BG tile fetcher (priority) and the PCM fetcher,
// with PCM anti-starvation, per-requester hit registers and a WAIT timeout.
module vball_rom_arbiter
    import vball_pkg::*;
#(
    parameter logic [ROM_AW-1:0] BG_BASE     = DEF_BG_BASE,
    parameter logic [ROM_AW-1:0] PCM_BASE    = DEF_PCM_BASE,
    parameter int unsigned       PCM_MAXWAIT = 4,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              bg_read,
    input  logic [BG_AW-1:0]  bg_addr,
    output logic [DATA_W-1:0] bg_data,
    output logic              bg_rdy,
    input  logic              pcm_read,
    input  logic [PCM_AW-1:0] pcm_addr,
    output logic [DATA_W-1:0] pcm_data,
    output logic              pcm_rdy,
    output logic              mem_rd,
    output logic [ROM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_rdy,
    output logic              timeout
);

    localparam int unsigned STARVE_W = (PCM_MAXWAIT > 0) ? $clog2(PCM_MAXWAIT + 1) : 1;
    localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STARVE_W-1:0] MAXWAIT_V  = STARVE_W'(PCM_MAXWAIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    arb_state_e           state, state_nxt;
    owner_e               owner, owner_nxt;
    logic [BG_AW-1:0]     fetch_addr, fetch_addr_nxt;
    logic [STARVE_W-1:0]  starve, starve_nxt;
    logic [TMO_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic                 mem_rd_nxt;
    logic [ROM_AW-1:0]    mem_addr_nxt;
    logic                 timeout_nxt;

    logic                 bg_pend, pcm_pend, bg_hit, pcm_hit;
    logic [BG_AW-1:0]     bg_addr_q;
    logic [PCM_AW-1:0]    pcm_addr_q;
    logic                 bg_clr, pcm_clr, bg_hit_ack, pcm_hit_ack;
    logic                 fill_en, deliver, inval;
    logic [DATA_W-1:0]    deliver_data;
    logic                 owner_pend;

    assign owner_pend = (owner == OWN_BG) ? bg_pend : pcm_pend;

    rom_req_slot #(.AW(BG_AW)) u_bg_slot (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_read     (bg_read),
        .req_addr     (bg_addr),
        .pend_clr     (bg_clr),
        .hit_ack      (bg_hit_ack),
        .fill_en      (fill_en && (owner == OWN_BG)),
        .fill_addr    (fetch_addr),
        .deliver_en   (deliver && (owner == OWN_BG)),
        .deliver_data (deliver_data),
        .inval        (inval && (owner == OWN_BG)),
        .pend         (bg_pend),
        .addr         (bg_addr_q),
        .hit_c        (bg_hit),
        .data         (bg_data),
        .rdy          (bg_rdy)
    );

    rom_req_slot #(.AW(PCM_AW)) u_pcm_slot (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_read     (pcm_read),
        .req_addr     (pcm_addr),
        .pend_clr     (pcm_clr),
        .hit_ack      (pcm_hit_ack),
        .fill_en      (fill_en && (owner == OWN_PCM)),
        .fill_addr    (PCM_AW'(fetch_addr)),
        .deliver_en   (deliver && (owner == OWN_PCM)),
        .deliver_data (deliver_data),
        .inval        (inval && (owner == OWN_PCM)),
        .pend         (pcm_pend),
        .addr         (pcm_addr_q),
        .hit_c        (pcm_hit),
        .data         (pcm_data),
        .rdy          (pcm_rdy)
    );

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_BG;
            fetch_addr <= '0;
            starve     <= '0;
            wait_cnt   <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            fetch_addr <= fetch_addr_nxt;
            starve     <= starve_nxt;
            wait_cnt   <= wait_cnt_nxt;
            mem_rd     <= mem_rd_nxt;
            mem_addr   <= mem_addr_nxt;
            timeout    <= timeout_nxt;
        end
    end

    // Arbitration, issue and completion.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        fetch_addr_nxt = fetch_addr;
        starve_nxt     = starve;
        wait_cnt_nxt   = wait_cnt;
        mem_rd_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        timeout_nxt    = timeout;
        bg_clr         = 1'b0;
        pcm_clr        = 1'b0;
        bg_hit_ack     = 1'b0;
        pcm_hit_ack    = 1'b0;
        fill_en        = 1'b0;
        deliver        = 1'b0;
        deliver_data   = mem_dout;
        inval          = 1'b0;

        if (!pcm_pend) begin
            starve_nxt = '0;
        end

        case (state)
            ST_IDLE: begin
                if (bg_hit) begin
                    bg_clr     = 1'b1;
                    bg_hit_ack = 1'b1;
                end else if (pcm_hit) begin
                    pcm_clr     = 1'b1;
                    pcm_hit_ack = 1'b1;
                end else if (bg_pend || pcm_pend) begin
                    if (pcm_pend && (!bg_pend || (starve >= MAXWAIT_V))) begin
                        owner_nxt      = OWN_PCM;
                        pcm_clr        = 1'b1;
                        fetch_addr_nxt = BG_AW'(pcm_addr_q);
                        mem_addr_nxt   = map_addr(PCM_BASE, ROM_AW'(pcm_addr_q));
                        starve_nxt     = '0;
                    end else begin
                        owner_nxt      = OWN_BG;
                        bg_clr         = 1'b1;
                        fetch_addr_nxt = bg_addr_q;
                        mem_addr_nxt   = map_addr(BG_BASE, ROM_AW'(bg_addr_q));
                        if (pcm_pend && (starve != STARVE_MAX)) begin
                            starve_nxt = starve + STARVE_W'(1);
                        end
                    end
                    mem_rd_nxt = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_nxt = '0;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rdy) begin
                    // A newer request from the owner makes this result stale for delivery.
                    fill_en   = 1'b1;
                    deliver   = !owner_pend;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == TMO_LAST) begin
                    deliver      = 1'b1;
                    deliver_data = {DATA_W{1'b1}};
                    inval        = 1'b1;
                    timeout_nxt  = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + TMO_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vball_rom_arbiter.sv
// Scoreboard bench for vball_rom_arbiter: stimulus pushes expected fetches/data, a monitor pops them.
module tb_vball_rom_arbiter;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b1;
    logic        bg_read  = 1'b0;
    logic [18:0] bg_addr  = '0;
    logic [7:0]  bg_data;
    logic        bg_rdy;
    logic        pcm_read = 1'b0;
    logic [17:0] pcm_addr = '0;
    logic [7:0]  pcm_data;
    logic        pcm_rdy;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic [7:0]  mem_dout = '0;
    logic        mem_rdy  = 1'b0;
    logic        timeout;

    int tests  = 0;
    int errors = 0;

    logic [24:0] exp_mem[$];
    logic [7:0]  exp_bg[$];
    logic [7:0]  exp_pcm[$];
    logic [24:0] mon_addr;
    logic [7:0]  mon_data;

    vball_rom_arbiter dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .bg_read  (bg_read),
        .bg_addr  (bg_addr),
        .bg_data  (bg_data),
        .bg_rdy   (bg_rdy),
        .pcm_read (pcm_read),
        .pcm_addr (pcm_addr),
        .pcm_data (pcm_data),
        .pcm_rdy  (pcm_rdy),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_rdy  (mem_rdy),
        .timeout  (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        errors++;
        $display("FAIL %s: unexpected output %0h with empty scoreboard", name, act);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_bg(input logic [18:0] a);
        bg_read = 1'b1;
        bg_addr = a;
        tick();
        bg_read = 1'b0;
    endtask

    task automatic wait_mem_rd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = mem_rd;
        end
        if (!seen) begin
            tests++;
            errors++;
            $display("FAIL wait_mem_rd: mem_rd not seen within 40 cycles");
        end
    endtask

    task automatic respond(input logic [7:0] d, input int dly);
        wait_mem_rd();
        repeat (dly) tick();
        mem_dout = d;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_sys);
                if (reset_n) begin
                    if (mem_rd) begin
                        if (exp_mem.size() == 0) unexpected("mem_rd", 32'(mem_addr));
                        else begin
                            mon_addr = exp_mem.pop_front();
                            check("mem_addr", 32'(mem_addr), 32'(mon_addr));
                        end
                    end
                    if (bg_rdy) begin
                        if (exp_bg.size() == 0) unexpected("bg_rdy", 32'(bg_data));
                        else begin
                            mon_data = exp_bg.pop_front();
                            check("bg_data", 32'(bg_data), 32'(mon_data));
                        end
                    end
                    if (pcm_rdy) begin
                        if (exp_pcm.size() == 0) unexpected("pcm_rdy", 32'(pcm_data));
                        else begin
                            mon_data = exp_pcm.pop_front();
                            check("pcm_data", 32'(pcm_data), 32'(mon_data));
                        end
                    end
                end
            end
        join_none

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_bg_rdy", 32'(bg_rdy), 32'd0);
        check("rst_pcm_rdy", 32'(pcm_rdy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_bg_data", 32'(bg_data), 32'd0);
        #2 reset_n = 1'b1;
        tick();

        // 1: miss fetch with latency checks, then same address hits
        exp_mem.push_back(25'h100010);
        exp_bg.push_back(8'hA5);
        pulse_bg(19'h00010);
        tick();
        check("miss_mem_rd_n2", 32'(mem_rd), 32'd1);
        tick();
        check("mem_rd_one_cycle", 32'(mem_rd), 32'd0);
        tick();
        tick();
        check("mem_addr_held", 32'(mem_addr), 32'h100010);
        mem_dout = 8'hA5;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        check("miss_rdy_m1", 32'(bg_rdy), 32'd1);
        tick();
        check("miss_rdy_pulse", 32'(bg_rdy), 32'd0);
        tick();
        exp_bg.push_back(8'hA5);
        pulse_bg(19'h00010);
        tick();
        check("hit_rdy_n2", 32'(bg_rdy), 32'd1);
        check("hit_no_mem_rd", 32'(mem_rd), 32'd0);
        repeat (4) tick();

        // 2: simultaneous requests, BG first; then a PCM hit
        exp_mem.push_back(25'h100020);
        exp_mem.push_back(25'h180004);
        exp_bg.push_back(8'h11);
        exp_pcm.push_back(8'h22);
        bg_read  = 1'b1;
        bg_addr  = 19'h00020;
        pcm_read = 1'b1;
        pcm_addr = 18'h00004;
        tick();
        bg_read  = 1'b0;
        pcm_read = 1'b0;
        respond(8'h11, 2);
        respond(8'h22, 3);
        repeat (3) tick();
        exp_pcm.push_back(8'h22);
        pcm_read = 1'b1;
        pcm_addr = 18'h00004;
        tick();
        pcm_read = 1'b0;
        repeat (4) tick();

        // 3: PCM starved by back-to-back BG requests is forced after 4 BG grants
        for (int i = 0; i < 4; i++) exp_mem.push_back(25'h100100 + 25'(i));
        exp_mem.push_back(25'h180008);
        exp_mem.push_back(25'h100104);
        for (int i = 0; i < 5; i++) exp_bg.push_back(8'h30 + 8'(i));
        exp_pcm.push_back(8'h44);
        bg_read  = 1'b1;
        bg_addr  = 19'h00100;
        pcm_read = 1'b1;
        pcm_addr = 18'h00008;
        tick();
        bg_read  = 1'b0;
        pcm_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_mem_rd();
            tick();
            tick();
            mem_dout = 8'h30 + 8'(i);
            mem_rdy  = 1'b1;
            bg_read  = 1'b1;
            bg_addr  = 19'h00101 + 19'(i);
            tick();
            mem_rdy  = 1'b0;
            bg_read  = 1'b0;
        end
        respond(8'h44, 2);
        respond(8'h34, 2);
        repeat (4) tick();

        // 4: newer BG request during flight suppresses the stale delivery
        exp_mem.push_back(25'h100200);
        exp_mem.push_back(25'h100201);
        exp_bg.push_back(8'h66);
        pulse_bg(19'h00200);
        wait_mem_rd();
        tick();
        pulse_bg(19'h00201);
        mem_dout = 8'h55;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        respond(8'h66, 2);
        repeat (4) tick();

        // 5: timeout, late mem_rdy ignored, hit register invalidated
        exp_mem.push_back(25'h100300);
        exp_bg.push_back(8'hFF);
        pulse_bg(19'h00300);
        wait_mem_rd();
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                tick();
                got = bg_rdy;
            end
            check("timeout_rdy_seen", 32'(got), 32'd1);
        end
        check("timeout_flag", 32'(timeout), 32'd1);
        tick();
        mem_dout = 8'h77;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        repeat (3) tick();
        check("late_rdy_bg_data", 32'(bg_data), 32'hFF);
        exp_mem.push_back(25'h100300);
        exp_bg.push_back(8'h12);
        pulse_bg(19'h00300);
        respond(8'h12, 2);
        repeat (2) tick();
        check("timeout_sticky", 32'(timeout), 32'd1);

        // 6: asynchronous reset mid-WAIT
        exp_mem.push_back(25'h100400);
        pulse_bg(19'h00400);
        wait_mem_rd();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_mem_rd", 32'(mem_rd), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_bg_rdy", 32'(bg_rdy), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_bg_data", 32'(bg_data), 32'd0);
        reset_n = 1'b1;
        tick();
        exp_mem.push_back(25'h100010);
        exp_bg.push_back(8'h99);
        pulse_bg(19'h00010);
        respond(8'h99, 2);
        repeat (6) tick();

        check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        check("exp_bg_drained", 32'(exp_bg.size()), 32'd0);
        check("exp_pcm_drained", 32'(exp_pcm.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
